// File: rtl/delay_timer_arbiter.sv
// -----------------------------------------------------------------------------
// delay_timer_arbiter
//
// Shares a single delay counter between NUM_REQ requesters. A round-robin
// arbiter picks one pending requester, its delay length is captured, the
// counter runs from 0 up to len-1, and the owner receives a one-cycle done
// pulse. Requesters are typically control FSMs waiting on settle/hold times.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   req        level request per requester, held until its done pulse
//   len        packed per-requester delay lengths, slice i = [i*CNT_WIDTH +: CNT_WIDTH]
//   abort      cancels the active delay (LOAD or RUN), no done pulse
//   busy       state is not IDLE
//   grant_vld  a requester owns the counter (LOAD, RUN, DONE)
//   grant_idx  index of the current/last owner (qualified by grant_vld)
//   cnt        current count value
//   done       one-hot, one-cycle completion pulse
// -----------------------------------------------------------------------------
module delay_timer_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]   len,
    input  logic                           abort,
    output logic                           busy,
    output logic                           grant_vld,
    output logic [IDX_WIDTH-1:0]           grant_idx,
    output logic [CNT_WIDTH-1:0]           cnt,
    output logic [NUM_REQ-1:0]             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   last_idx;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic [IDX_WIDTH-1:0]   cand;
    logic                   pick_vld;
    logic [CNT_WIDTH-1:0]   len_q;
    logic                   terminal;
    logic [CNT_WIDTH-1:0]   len_arr [NUM_REQ];

    // Unpack the flat length bus so the owner's slice can be selected by index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign len_arr[i] = len[i*CNT_WIDTH +: CNT_WIDTH];
    end

    // Round-robin pick: first set request searching upward from last_idx+1,
    // wrapping; last_idx itself is examined last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_WIDTH'((int'(last_idx) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // len_q == 0 is treated like a length of 1 so the count never wraps.
    assign terminal = (len_q == '0) || (cnt == len_q - CNT_WIDTH'(1));

    // Status flags decode the state register directly, so they are glitch-free
    // and aligned with the registered outputs.
    assign busy      = (state != IDLE);
    assign grant_vld = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_WIDTH'(NUM_REQ - 1);
            cnt       <= '0;
            done      <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_idx <= pick_idx;
                        last_idx  <= pick_idx;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        len_q <= len_arr[grant_idx];
                        state <= RUN;
                    end
                end
                RUN: begin
                    // abort wins over the terminal transition; last_idx keeps
                    // the aborted owner so the pointer still advances past it.
                    if (abort) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (terminal) begin
                        done[grant_idx] <= 1'b1;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_delay_timer_arbiter
//
// Directed testbench for delay_timer_arbiter (NUM_REQ=4, CNT_WIDTH=16).
// Inputs are changed after a rising edge; outputs are sampled 1 ns after it.
// -----------------------------------------------------------------------------
module tb_delay_timer_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int CNT_WIDTH = 16;
    localparam int IDX_WIDTH = 2;

    logic                         clk;
    logic                         rst_n;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*CNT_WIDTH-1:0] len;
    logic                         abort;
    logic                         busy;
    logic                         grant_vld;
    logic [IDX_WIDTH-1:0]         grant_idx;
    logic [CNT_WIDTH-1:0]         cnt;
    logic [NUM_REQ-1:0]           done;

    int n_checks = 0;
    int n_pass   = 0;

    delay_timer_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .CNT_WIDTH (CNT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .cnt       (cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int idx, input int val);
        len[idx*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(val);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_gvld"}, 32'(grant_vld), 32'd0);
        check({tag, "_cnt"},  32'(cnt), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    int exp_rr [9] = '{0, 1, 2, 3, 0, 1, 3, 0, 1};

    initial begin
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        abort = 1'b0;

        // Reset state
        tick();
        check_idle("rst");
        check("rst_gidx", 32'(grant_idx), 32'd0);
        rst_n = 1'b1;
        tick();
        check_idle("rst_idle");

        // Basic delay, len[0]=5
        set_len(0, 5);
        req = 4'b0001;
        tick();
        check("b_gvld", 32'(grant_vld), 32'd1);
        check("b_gidx", 32'(grant_idx), 32'd0);
        check("b_busy", 32'(busy), 32'd1);
        for (int c = 2; c <= 6; c++) begin
            tick();
            check("b_cnt", 32'(cnt), 32'(c - 2));
            check("b_nodone", 32'(done), 32'd0);
        end
        tick();
        check("b_done", 32'(done), 32'b0001);
        check("b_cnt_hold", 32'(cnt), 32'd4);
        req = 4'b0000;
        tick();
        check_idle("b_end");

        // Zero length on requester 2
        set_len(2, 0);
        req = 4'b0100;
        tick();
        check("z_gidx", 32'(grant_idx), 32'd2);
        check("z_done0", 32'(done), 32'd0);
        tick();
        check("z_cnt", 32'(cnt), 32'd0);
        check("z_done1", 32'(done), 32'd0);
        tick();
        check("z_done", 32'(done), 32'b0100);
        req = 4'b0000;
        tick();
        check_idle("z_end");

        // Round-robin from a fresh reset, all requesters, len=2
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_len(i, 2);
        req = 4'b1111;
        for (int g = 0; g < 9; g++) begin
            if (g == 6) req = 4'b1011;   // pointer is at 1: expect 3, 0, 1
            tick();
            check("rr_gidx", 32'(grant_idx), 32'(exp_rr[g]));
            tick();
            check("rr_cnt0", 32'(cnt), 32'd0);
            tick();
            check("rr_cnt1", 32'(cnt), 32'd1);
            check("rr_nodone", 32'(done), 32'd0);
            tick();
            check("rr_done", 32'(done), 32'(1 << exp_rr[g]));
            tick();
            check("rr_idle", 32'(busy), 32'd0);
        end

        // Abort during RUN at cnt=3 (len=10); pointer last at 1
        set_len(0, 10);
        set_len(1, 10);
        req = 4'b0001;
        tick();
        check("a_gidx", 32'(grant_idx), 32'd0);
        for (int c = 0; c <= 3; c++) tick();
        check("a_cnt3", 32'(cnt), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("a_idle");
        req = 4'b1111;
        tick();
        check("a_next", 32'(grant_idx), 32'd1);
        check("a_nodone", 32'(done), 32'd0);

        // Reset mid-run
        tick();
        tick();
        check("r_cnt1", 32'(cnt), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("r_rst");
        check("r_gidx", 32'(grant_idx), 32'd0);
        tick();
        check("r_prio0", 32'(grant_idx), 32'd0);
        check("r_gvld", 32'(grant_vld), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/delay_timer_arbiter.md
Name: delay_timer_arbiter

Overview:
- Shares one internal delay counter between NUM_REQ requesters using round-robin arbitration.
- Each requester asks for a delay of a given length. The block grants one requester at a time, loads the length, counts it out, then pulses that requester's done bit.
- Sits between control FSMs that need timed waits (e.g. settle or hold timers) and the single count datapath, so each requester does not need its own counter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_WIDTH, 16, width of the delay length and of the count.
- IDX_WIDTH, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  level request per requester; held high until done pulses.
- len  input  NUM_REQ*CNT_WIDTH  per-requester delay length; slice i is bits [i*CNT_WIDTH +: CNT_WIDTH].
- abort  input  1  cancels the active delay.
- busy  output  1  high whenever the state is not IDLE.
- grant_vld  output  1  high in LOAD, RUN and DONE.
- grant_idx  output  IDX_WIDTH  index of the current owner.
- cnt  output  CNT_WIDTH  current count value.
- done  output  NUM_REQ  one-hot, one-cycle completion pulse.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - busy, grant_vld, grant_idx, cnt and done all become 0.
  - Round-robin pointer last_idx becomes NUM_REQ-1, so req[0] has top priority after reset.
  - Reset overrides everything, including a run in progress; no done pulse is issued.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from (last_idx+1) mod NUM_REQ, wrapping around.
  - Register the winner into grant_idx and last_idx, then go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD (one cycle):
  - len_q <= len slice[grant_idx]; cnt <= 0; go to RUN.
  - len changes outside this cycle have no effect on the active run.
- RUN:
  - Terminal condition: cnt == len_q-1, or len_q == 0.
  - If terminal, go to DONE (cnt holds its value); otherwise cnt <= cnt+1.
  - len_q=0 behaves exactly like len_q=1 (one RUN cycle, cnt=0).
  - Maximum length 2^CNT_WIDTH-1: cnt never wraps.
- DONE (one cycle): done[grant_idx]=1, then go to IDLE with cnt <= 0.
- Latency, with req sampled in IDLE at edge 0:
  - LOAD in cycle 1, RUN in cycles 2..L+1, done in cycle L+2, IDLE in cycle L+3.
  - Back-to-back service period is L+3 cycles per grant.
- abort:
  - High in LOAD or RUN: next state is IDLE, cnt <= 0, no done pulse. last_idx keeps the aborted index, so the pointer still advances.
  - Ignored in IDLE and DONE.
  - Takes priority over the RUN terminal transition.
- Requester contract:
  - The owner drops req on the edge where it sees done.
  - If req stays high, that requester is re-eligible, but only after the others it is behind in round-robin order.
  - The owner dropping req mid-run does not stop the run; done still pulses.
- grant_idx holds its last value in IDLE. grant_vld qualifies it.
- done is never multi-hot.

Test Plan:
- Basic delay: reset, then req=0001, len[0]=5 at cycle 0 -> grant_vld and grant_idx=0 in cycle 1; cnt=0,1,2,3,4 in cycles 2-6; done=0001 in cycle 7 only; busy=0 in cycle 8.
- Zero length: req[2] with len[2]=0 -> exactly one RUN cycle with cnt=0; done=0100 three cycles after the request.
- Round-robin: all req high, every len=2, req held high -> grant order 0,1,2,3,0,1; one done every 5 cycles; no requester granted twice in a row.
- Simultaneous requests after a grant to 1: req=1011 -> next grant goes to 3, then 0, then 1 (wrap-around).
- Abort: abort=1 during RUN at cnt=3 with len=10 -> IDLE next cycle; no done pulse; cnt=0; the next grant goes to the index after the aborted one.
- Reset mid-run: rst_n=0 for one cycle during RUN -> all outputs 0 next cycle; no done pulse; the next arbitration gives priority to req[0].
